aes_word_stream_ctrl: RTL and testbench

- Upstream/downstream control stage for the AES-128 decryption core.
- Collects eight 32-bit words from a valid/ready stream: 4 key words, then 4 encrypted-message words.
- Drives the core's Cipherkey, Plaintext (encrypted block in) and Run. Waits for completion, then returns the core's 128-bit Ciphertext (decrypted block out) as 4 words on an output valid/ready stream.
- Sits between the SoC bus bridge and the AES core and owns the entire core handshake.

---
 rtl/aes_word_stream_ctrl.sv | 133 +++++++++++++
 tb/tb_aes_word_stream_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_word_stream_ctrl.sv
// AES-128 decrypt-core front end: 8 words in (4 key words, 4 message words, MSW first), 4 result words out.
// Latency: core_run 2 cycles after word 7; out_valid 1 cycle after core_ready in WAIT_DONE.
// Backpressure: in_ready low outside LOAD; out_ready low holds out_data. AES_WSC_TIMEOUT_EN adds a watchdog.
module aes_word_stream_ctrl #(
    parameter int BUSY_CNT_W     = 16,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [31:0]           in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          core_key,
    output logic [127:0]          core_msg,
    output logic                  core_run,
    input  logic                  core_ready,
    input  logic [127:0]          core_result,
    output logic [BUSY_CNT_W-1:0] busy_cycles,
    output logic                  error
);

    typedef enum logic [2:0] {
        LOAD,
        ARM,
        RUN,
        WAIT_GUARD,
        WAIT_DONE,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [2:0]            cnt;
    logic [127:0]          result;
    logic [BUSY_CNT_W-1:0] busy_cnt;
    logic [BUSY_CNT_W-1:0] busy_inc;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  timeout_hit;
    logic [6:0]            word_lsb;

    // The watchdog compare value must be reachable by the saturating counter.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** BUSY_CNT_W) - 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES does not fit in BUSY_CNT_W bits");
    end

    // Word 0 of each group lands in bits [127:96], so the slot offset is (3 - idx) * 32.
    assign word_lsb = {~cnt[1:0], 5'd0};
    assign out_data = result[word_lsb +: 32];
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign busy_inc = (busy_cnt == {BUSY_CNT_W{1'b1}}) ? busy_cnt : busy_cnt + 1'b1;

`ifdef AES_WSC_TIMEOUT_EN
    logic error_q;

    assign timeout_hit = (busy_inc == BUSY_CNT_W'(TIMEOUT_CYCLES));
    assign error       = error_q;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else if (state == WAIT_DONE && !core_ready && timeout_hit) begin
            error_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:       if (in_xfer && cnt == 3'd7) state_nx = ARM;
            ARM:        if (core_ready) state_nx = RUN;
            RUN:        state_nx = WAIT_GUARD;
            // Core Ready has not dropped yet in the cycle after Run, so it is not trusted here.
            WAIT_GUARD: state_nx = WAIT_DONE;
            WAIT_DONE:  if (core_ready || timeout_hit) state_nx = DRAIN;
            DRAIN:      if (out_xfer && cnt == 3'd3) state_nx = LOAD;
            default:    state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= LOAD;
            cnt         <= 3'd0;
            core_key    <= '0;
            core_msg    <= '0;
            result      <= '0;
            busy_cnt    <= '0;
            busy_cycles <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            core_run    <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == LOAD);
            out_valid <= (state_nx == DRAIN);
            core_run  <= (state_nx == RUN);
            case (state)
                LOAD: begin
                    if (in_xfer) begin
                        if (cnt[2]) core_msg[word_lsb +: 32] <= in_data;
                        else        core_key[word_lsb +: 32] <= in_data;
                        cnt <= cnt + 3'd1;
                    end
                end
                WAIT_GUARD: busy_cnt <= '0;
                WAIT_DONE: begin
                    busy_cnt <= busy_inc;
                    if (core_ready) begin
                        result      <= core_result;
                        busy_cycles <= busy_inc;
                    end else if (timeout_hit) begin
                        result      <= '0;
                        busy_cycles <= busy_inc;
                    end
                end
                DRAIN: begin
                    if (out_xfer) cnt <= (cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_word_stream_ctrl.sv
// Randomized bench for aes_word_stream_ctrl with a behavioural AES core stand-in and block-level model.
module tb_aes_word_stream_ctrl;
    localparam int TO = 20;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] core_key;
    logic [127:0] core_msg;
    logic         core_run;
    logic         core_ready;
    logic [127:0] core_result;
    logic [15:0]  busy_cycles;
    logic         error;

    aes_word_stream_ctrl #(.BUSY_CNT_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .Reset(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_key(core_key), .core_msg(core_msg), .core_run(core_run),
        .core_ready(core_ready), .core_result(core_result),
        .busy_cycles(busy_cycles), .error(error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Stand-in for AES-128 decryption: exact for the FIPS-197 vector, an arbitrary bijection otherwise.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] m);
        if (k == FIPS_KEY && m == FIPS_CT) return FIPS_PT;
        return k ^ {m[63:0], m[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // Core model: Ready drops one edge after Run is sampled, stays low lat_cfg cycles (or forever if stuck).
    int  lat_cfg = 3;
    bit  stuck = 1'b0;
    bit  pend;
    int  lowleft;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready  <= 1'b1;
            core_result <= '0;
            pend        <= 1'b0;
            lowleft     <= 0;
        end else if (core_run) begin
            pend <= 1'b1;
        end else if (pend) begin
            pend       <= 1'b0;
            core_ready <= 1'b0;
            lowleft    <= lat_cfg;
        end else if (!core_ready && !stuck) begin
            if (lowleft > 1) lowleft <= lowleft - 1;
            else begin
                core_ready  <= 1'b1;
                core_result <= aes_ref(core_key, core_msg);
            end
        end
    end

    bit rand_out = 1'b0;
    bit out_force = 1'b1;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = rand_out ? 1'($urandom_range(0, 1)) : out_force;
        end
    end

    // Block-level model state.
    logic [31:0]  exp_q[$];
    logic [31:0]  got_q[$];
    logic [255:0] blk_q[$];
    logic [255:0] cur_blk;
    logic [31:0]  prev_od;
    logic [15:0]  busy_exp;
    bit counting, prev_run, prev_ov, prev_stall, exp_err, timeout_expect;
    int lowcnt = 0;
    int out_xfers = 0;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            counting = 0; prev_run = 0; prev_ov = 0; prev_stall = 0; exp_err = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_data", 128'(out_data), 128'(prev_od));
            end
            if (core_run) begin
                chk("run_width", 128'(prev_run), 128'(0));
                chk("run_has_block", 128'(blk_q.size() != 0), 128'(1));
                if (blk_q.size() != 0) begin
                    cur_blk = blk_q.pop_front();
                    chk("run_key", core_key, cur_blk[255:128]);
                    chk("run_msg", core_msg, cur_blk[127:0]);
                end
                counting = 1; lowcnt = 0;
            end else if (out_valid && !prev_ov) begin
                if (timeout_expect) begin
                    exp_err = 1;
                    chk("timeout_cycle", 128'(lowcnt), 128'(TO));
                    busy_exp = 16'(TO);
                end else begin
                    busy_exp = 16'(lowcnt + 1);
                end
                chk("key_held", core_key, cur_blk[255:128]);
                chk("msg_held", core_msg, cur_blk[127:0]);
                counting = 0;
            end else if (counting && !core_ready) begin
                lowcnt++;
            end
            if (out_valid) chk("busy_cycles", 128'(busy_cycles), 128'(busy_exp));
            chk("error", 128'(error), 128'(exp_err));
            if (out_valid && out_ready) begin
                chk("out_has_word", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) chk("out_data", 128'(out_data), 128'(exp_q.pop_front()));
                got_q.push_back(out_data);
                out_xfers++;
            end
            prev_stall = out_valid && !out_ready;
            prev_od    = out_data;
            prev_run   = core_run;
            prev_ov    = out_valid;
        end
    end

    task automatic put_word(input logic [31:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (t >= 600) chk("in_accept_timeout", 128'(t), 128'(0));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] m, input bit gaps, input bit zero_res);
        logic [255:0] blk;
        logic [127:0] res;
        blk = {k, m};
        res = zero_res ? '0 : aes_ref(k, m);
        blk_q.push_back(blk);
        for (int i = 0; i < 4; i++) exp_q.push_back(res[127-32*i -: 32]);
        for (int i = 0; i < 8; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_data = $urandom;
                @(negedge clk);
            end
            put_word(blk[255-32*i -: 32]);
        end
        chk("in_ready_after_w7", 128'(in_ready), 128'(0));
    endtask

    task automatic wait_drained();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 128'(t < 2000), 128'(1));
        chk("load_reentered", 128'(in_ready), 128'(1));
    endtask

    task automatic pulse_reset();
        #3 rst = 1'b1;
        exp_q.delete();
        blk_q.delete();
        @(negedge clk);
        #2;
        chk("rst_core_run", 128'(core_run), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_error", 128'(error), 128'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));
        chk("post_rst_out_valid", 128'(out_valid), 128'(0));
    endtask

    logic [31:0] fips_words [4];

    task automatic check_fips_words();
        chk("fips_count", 128'(got_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("fips_word", 128'(got_q[i]), 128'(fips_words[i]));
    endtask

    initial begin
        int t;
        int x0;
        fips_words = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_data", 128'(out_data), 128'(0));
        chk("reset_core_run", 128'(core_run), 128'(0));
        chk("reset_core_key", core_key, 128'(0));
        chk("reset_core_msg", core_msg, 128'(0));
        chk("reset_busy", 128'(busy_cycles), 128'(0));
        chk("reset_error", 128'(error), 128'(0));
        #2 rst = 1'b0;
        @(negedge clk);
        chk("first_in_ready", 128'(in_ready), 128'(1));

        // FIPS-197 vector with a free-running consumer.
        got_q.delete();
        send_block(FIPS_KEY, FIPS_CT, 1'b0, 1'b0);
        wait_drained();
        check_fips_words();

        // Consumer stalls for 10 cycles at the first result word.
        out_force = 1'b0;
        x0 = out_xfers;
        send_block(FIPS_KEY, FIPS_CT, 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stall_reach_drain", 128'(out_valid), 128'(1));
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_data", 128'(out_data), 128'(32'h00112233));
        end
        out_force = 1'b1;
        wait_drained();
        chk("stall_xfers", 128'(out_xfers - x0), 128'(4));

        // Random blocks, random input gaps, random consumer, random core latency.
        rand_out = 1'b1;
        for (int b = 0; b < 6; b++) begin
            lat_cfg = $urandom_range(1, 12);
            send_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        end
        wait_drained();
        rand_out = 1'b0;

        // Back-to-back: same key, FIPS ciphertext then an all-zero message.
        lat_cfg = 4;
        send_block(FIPS_KEY, FIPS_CT, 1'b0, 1'b0);
        send_block(FIPS_KEY, 128'(0), 1'b0, 1'b0);
        wait_drained();

        // Reset while the core is busy, then a clean block.
        lat_cfg = 30;
        send_block(FIPS_KEY, FIPS_CT, 1'b0, 1'b0);
        t = 0;
        while (!(counting && lowcnt >= 5) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reached_wait_done", 128'(t < 200), 128'(1));
        pulse_reset();
        lat_cfg = 5;
        got_q.delete();
        send_block(FIPS_KEY, FIPS_CT, 1'b0, 1'b0);
        wait_drained();
        check_fips_words();

`ifdef AES_WSC_TIMEOUT_EN
        // Core never completes: watchdog drains four zero words and latches error.
        stuck = 1'b1;
        timeout_expect = 1'b1;
        x0 = out_xfers;
        send_block(FIPS_KEY, FIPS_CT, 1'b0, 1'b1);
        wait_drained();
        timeout_expect = 1'b0;
        chk("timeout_xfers", 128'(out_xfers - x0), 128'(4));
        repeat (5) begin
            @(negedge clk);
            chk("error_sticky", 128'(error), 128'(1));
        end
        stuck = 1'b0;
        pulse_reset();
        chk("error_cleared", 128'(error), 128'(0));
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
